// File: rtl/commit_alloc_pkg.sv
// commit_alloc_pkg: shared commit-ring sizes and pointer/count types
package commit_alloc_pkg;
    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = 5;
    localparam int NDEC     = 4;
    typedef logic [LNCOMMIT-1:0] slot_t;
    typedef logic [LNCOMMIT:0]   cnt_t;
endpackage

// File: rtl/commit_alloc_ring_span_mask.sv
// ring_span_mask: wrapped mask of count slots starting at start on an N-slot ring
module ring_span_mask #(
    parameter int N  = 32,
    parameter int LN = 5
) (
    input  logic [LN-1:0] start,
    input  logic [LN:0]   count,
    output logic [N-1:0]  mask
);
    // slot i is inside the span when its ring distance from start is below count
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [LN-1:0] off;
        assign off     = LN'(i) - start;
        assign mask[i] = {1'b0, off} < count;
    end
endmodule

// File: rtl/commit_alloc.sv
// commit_alloc: head/tail allocator for the commit-station ring with retire and flush rollback
module commit_alloc
    import commit_alloc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  slot_t              alloc_count,
    input  cnt_t               retire_count,
    input  logic               flush,
    input  slot_t              flush_addr,
    output slot_t              next_start,
    output slot_t              current_start,
    output slot_t              current_end,
    output cnt_t               current_available,
    output logic [NCOMMIT-1:0] live_mask,
    output logic               empty,
    output logic               full,
    output logic               alloc_error
);
    slot_t              head, tail, head_n;
    cnt_t               live, rc, ac, live_r, live_f;
    logic               retire_ok, alloc_ok;
    logic [NCOMMIT-1:0] set_mask, clr_mask, flush_mask;

    // legality and effective counts, all from pre-edge state
    always_comb begin
        retire_ok = retire_count <= live;
        alloc_ok  = {1'b0, alloc_count} <= current_available;
        rc        = retire_ok ? retire_count : '0;
        ac        = (!flush && alloc_ok) ? {1'b0, alloc_count} : '0;
        head_n    = head + rc[LNCOMMIT-1:0];
        live_r    = live - rc;
        live_f    = {1'b0, flush_addr - head_n};
    end

    ring_span_mask #(.N(NCOMMIT), .LN(LNCOMMIT)) u_clr (.start(head), .count(rc), .mask(clr_mask));
    ring_span_mask #(.N(NCOMMIT), .LN(LNCOMMIT)) u_set (.start(tail), .count(ac), .mask(set_mask));
    ring_span_mask #(.N(NCOMMIT), .LN(LNCOMMIT)) u_fl  (.start(head_n), .count(live_f), .mask(flush_mask));

    // retire advances head first; flush then rewinds tail, otherwise allocation extends it
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            live        <= '0;
            live_mask   <= '0;
            alloc_error <= 1'b0;
        end else begin
            head        <= head_n;
            tail        <= flush ? flush_addr : tail + ac[LNCOMMIT-1:0];
            live        <= flush ? live_f : live_r + ac;
            live_mask   <= flush ? flush_mask : (live_mask & ~clr_mask) | set_mask;
            alloc_error <= alloc_error | !retire_ok | (!flush && !alloc_ok);
        end
    end

    assign next_start        = tail;
    assign current_start     = head;
    assign current_end       = tail - 1'b1;
    assign current_available = cnt_t'(NCOMMIT) - live;
    assign empty             = live == '0;
    assign full              = live[LNCOMMIT];
endmodule
